iob_pfsm_loader: RTL and testbench



---
 rtl/iob_pfsm_loader.sv | 161 ++++++++++++++++
 tb/tb_iob_pfsm_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_pfsm_loader.sv
// PFSM LUT loader: SOFTRESET on, per-word MEMORY_WORD_SELECT + LUT writes fed from a stream, SOFTRESET off.
// Each CSR write or LUT entry costs >= 2 cycles; one IOb write in flight, stream held off (s_ready_o=0) while it is pending.
module iob_pfsm_loader #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned STATE_W        = 2,
  parameter int unsigned INPUT_W        = 1,
  parameter int unsigned OUTPUT_W       = 1,
  parameter int unsigned SOFTRESET_ADDR = 32'h0000,
  parameter int unsigned WORD_SEL_ADDR  = 32'h0004,
  parameter int unsigned MEMORY_ADDR    = 32'h0100
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i
);

  localparam int unsigned EW        = INPUT_W + STATE_W;
  localparam int unsigned N_ENTRIES = 2 ** EW;
  localparam int unsigned N_WORDS   = (STATE_W + OUTPUT_W + DATA_W - 1) / DATA_W;
  localparam int unsigned WW        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned BSHIFT    = $clog2(DATA_W / 8);
  localparam int unsigned STRB_W    = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    SRST_ON,
    SEL,
    DATA,
    SRST_OFF,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       e_q, e_d;
  logic [WW-1:0]       w_q, w_d;
  logic                avalid_q, avalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                beat;
  logic                wr_done;
  logic [ADDR_W-1:0]   mem_addr;

  // A beat is only taken when the state can actually advance this cycle.
  assign s_ready_o    = cke_i && !rst_i && (state_q == DATA) && !avalid_q;
  assign beat         = s_valid_i && s_ready_o;
  assign wr_done      = avalid_q && iob_ready_i;
  assign mem_addr     = ADDR_W'(MEMORY_ADDR) + (ADDR_W'(e_q) << BSHIFT);

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = avalid_q ? {STRB_W{1'b1}} : {STRB_W{1'b0}};

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    w_d      = w_q;
    avalid_d = avalid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SRST_ON;
          e_d     = '0;
          w_d     = '0;
        end
      end
      SRST_ON: begin
        if (!avalid_q) begin
          avalid_d = 1'b1;
          addr_d   = ADDR_W'(SOFTRESET_ADDR);
          wdata_d  = DATA_W'(1);
        end else if (iob_ready_i) begin
          avalid_d = 1'b0;
          state_d  = SEL;
        end
      end
      SEL: begin
        if (!avalid_q) begin
          avalid_d = 1'b1;
          addr_d   = ADDR_W'(WORD_SEL_ADDR);
          wdata_d  = DATA_W'(w_q);
        end else if (iob_ready_i) begin
          avalid_d = 1'b0;
          e_d      = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          avalid_d = 1'b1;
          addr_d   = mem_addr;
          wdata_d  = s_data_i;
        end else if (wr_done) begin
          avalid_d = 1'b0;
          // Terminal compare before increment keeps e from wrapping.
          if (e_q != EW'(N_ENTRIES - 1)) begin
            e_d = e_q + 1'b1;
          end else if (w_q != WW'(N_WORDS - 1)) begin
            w_d     = w_q + 1'b1;
            state_d = SEL;
          end else begin
            state_d = SRST_OFF;
          end
        end
      end
      SRST_OFF: begin
        if (!avalid_q) begin
          avalid_d = 1'b1;
          addr_d   = ADDR_W'(SOFTRESET_ADDR);
          wdata_d  = '0;
        end else if (iob_ready_i) begin
          avalid_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        avalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      e_q      <= '0;
      w_q      <= '0;
      avalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (cke_i) begin
      state_q  <= state_d;
      e_q      <= e_d;
      w_q      <= w_d;
      avalid_q <= avalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_iob_pfsm_loader.sv
// Scoreboard bench: directed start/stream scenarios on a default instance and a 128-entry, 2-word instance.
module tb_iob_pfsm_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cke, iob_ready;
  logic        start_a, busy_a, done_a, s_valid_a, s_ready_a, avalid_a;
  logic [31:0] s_data_a, wdata_a;
  logic [15:0] addr_a;
  logic [3:0]  wstrb_a;
  logic        start_b, busy_b, done_b, s_valid_b, s_ready_b, avalid_b;
  logic [7:0]  s_data_b, wdata_b;
  logic [15:0] addr_b;
  logic [0:0]  wstrb_b;

  int  checks = 0;
  int  failures = 0;
  int  taken_a = 0, taken_b = 0;
  int  avail_a = 0, avail_b = 0;
  int  done_cnt_a = 0, done_cnt_b = 0;
  bit  take_a = 1'b0, take_b = 1'b0;
  bit  ready_mode = 1'b0, gaps = 1'b0;
  wr_t exp_a[$];
  wr_t exp_b[$];

  iob_pfsm_loader dut_a (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a),
    .s_data_i(s_data_a), .s_valid_i(s_valid_a), .s_ready_o(s_ready_a),
    .iob_avalid_o(avalid_a), .iob_addr_o(addr_a), .iob_wdata_o(wdata_a),
    .iob_wstrb_o(wstrb_a), .iob_ready_i(iob_ready)
  );

  iob_pfsm_loader #(.DATA_W(8), .STATE_W(6), .OUTPUT_W(4), .INPUT_W(1)) dut_b (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b),
    .s_data_i(s_data_b), .s_valid_i(s_valid_b), .s_ready_o(s_ready_b),
    .iob_avalid_o(avalid_b), .iob_addr_o(addr_b), .iob_wdata_o(wdata_b),
    .iob_wstrb_o(wstrb_b), .iob_ready_i(iob_ready)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Full default-geometry sequence; stream beat k carries data k.
  task automatic push_a(input int base);
    exp_a.push_back({16'h0000, 32'd1});
    exp_a.push_back({16'h0004, 32'd0});
    for (int i = 0; i < 8; i++) exp_a.push_back({16'(16'h0100 + i * 4), 32'(base + i)});
    exp_a.push_back({16'h0000, 32'd0});
  endtask

  task automatic push_b();
    exp_b.push_back({16'h0000, 32'd1});
    for (int w = 0; w < 2; w++) begin
      exp_b.push_back({16'h0004, 32'(w)});
      for (int i = 0; i < 128; i++) exp_b.push_back({16'(16'h0100 + i), 32'((w * 128 + i) % 256)});
    end
    exp_b.push_back({16'h0000, 32'd0});
  endtask

  task automatic wait_done(input bit sel_b, input int bound, output int cyc);
    cyc = 0;
    while (!(sel_b ? done_b : done_a) && cyc < bound) begin
      tick();
      cyc++;
    end
    chk(sel_b ? "b_done_seen" : "a_done_seen", 64'(sel_b ? done_b : done_a), 64'd1);
  endtask

  // Stream sources and slave ready, driven just after each rising edge.
  initial begin
    s_valid_a = 1'b0; s_data_a = '0; s_valid_b = 1'b0; s_data_b = '0; iob_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (take_a) taken_a++;
      if (take_b) taken_b++;
      if (!(s_valid_a && !take_a))
        s_valid_a = (taken_a < avail_a) && (!gaps || $urandom_range(0, 2) != 0);
      s_data_a  = 32'(taken_a);
      s_valid_b = (taken_b < avail_b);
      s_data_b  = 8'(taken_b);
      iob_ready = ready_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor: sample on the falling edge what the next rising edge will commit.
  initial begin
    wr_t         e;
    bit          stall_a;
    logic [15:0] p_addr;
    logic [31:0] p_wdata;
    stall_a = 1'b0;
    p_addr  = '0;
    p_wdata = '0;
    forever begin
      @(negedge clk);
      take_a = s_valid_a && s_ready_a;
      take_b = s_valid_b && s_ready_b;
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (stall_a) begin
        chk("a_hold_avalid", 64'(avalid_a), 64'd1);
        chk("a_hold_addr", 64'(addr_a), 64'(p_addr));
        chk("a_hold_wdata", 64'(wdata_a), 64'(p_wdata));
      end
      stall_a = avalid_a && !rst && !(iob_ready && cke);
      p_addr  = addr_a;
      p_wdata = wdata_a;
      if (!rst && cke && avalid_a && iob_ready) begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_extra_write addr=0x%0h data=0x%0h expected none", addr_a, wdata_a);
        end else begin
          e = exp_a.pop_front();
          chk("a_wr_addr", 64'(addr_a), 64'(e.addr));
          chk("a_wr_data", 64'(wdata_a), 64'(e.data));
          chk("a_wr_strb", 64'(wstrb_a), 64'hF);
        end
      end
      if (!rst && cke && avalid_b && iob_ready) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_extra_write addr=0x%0h data=0x%0h expected none", addr_b, wdata_b);
        end else begin
          e = exp_b.pop_front();
          chk("b_wr_addr", 64'(addr_b), 64'(e.addr));
          chk("b_wr_data", 64'(wdata_b), 64'(e.data));
          chk("b_wr_strb", 64'(wstrb_b), 64'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    int saved;
    rst = 1'b1; cke = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_sready", 64'(s_ready_a), 64'd0);
    chk("rst_avalid", 64'(avalid_a), 64'd0);
    chk("rst_addr", 64'(addr_a), 64'd0);
    chk("rst_wdata", 64'(wdata_a), 64'd0);
    chk("rst_wstrb", 64'(wstrb_a), 64'd0);
    chk("rst_b_avalid", 64'(avalid_b), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy_a), 64'd0);

    // Defaults, always ready, always valid.
    push_a(0); avail_a = 8;
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t1_busy", 64'(busy_a), 64'd1);
    wait_done(1'b0, 100, cyc);
    chk("t1_latency", 64'(cyc), 64'd22);
    tick();
    chk("t1_done_once", 64'(done_cnt_a), 64'd1);
    chk("t1_done_low", 64'(done_a), 64'd0);
    chk("t1_busy_low", 64'(busy_a), 64'd0);
    chk("t1_sb_empty", 64'(exp_a.size()), 64'd0);
    chk("t1_beats", 64'(taken_a), 64'd8);

    // Start in the cycle after done; random ready and gaps; stray start mid-DATA.
    push_a(8); avail_a = 16; ready_mode = 1'b1; gaps = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t2_busy", 64'(busy_a), 64'd1);
    n = 0;
    while (!s_ready_a && n < 200) begin tick(); n++; end
    chk("t2_reach_data", 64'(s_ready_a), 64'd1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(1'b0, 2000, cyc);
    tick();
    chk("t2_done_cnt", 64'(done_cnt_a), 64'd2);
    chk("t2_sb_empty", 64'(exp_a.size()), 64'd0);
    chk("t2_beats", 64'(taken_a), 64'd16);
    ready_mode = 1'b0; gaps = 1'b0;

    // Clock enable low for 5 cycles while entry 4 write is pending.
    push_a(16); avail_a = 24;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!(avalid_a && addr_a == 16'h0110) && n < 200) begin tick(); n++; end
    chk("t3_reach_0110", 64'(avalid_a && addr_a == 16'h0110), 64'd1);
    cke = 1'b0;
    saved = taken_a;
    repeat (5) begin
      tick();
      chk("t3_sready_low", 64'(s_ready_a), 64'd0);
    end
    chk("t3_hold_avalid", 64'(avalid_a), 64'd1);
    chk("t3_hold_addr", 64'(addr_a), 64'h0110);
    chk("t3_hold_wdata", 64'(wdata_a), 64'd20);
    chk("t3_no_beat", 64'(taken_a), 64'(saved));
    cke = 1'b1;
    wait_done(1'b0, 200, cyc);
    tick();
    chk("t3_done_cnt", 64'(done_cnt_a), 64'd3);
    chk("t3_sb_empty", 64'(exp_a.size()), 64'd0);
    chk("t3_beats", 64'(taken_a), 64'd24);

    // Reset while entry 3 write is outstanding, then a clean restart.
    exp_a.push_back({16'h0000, 32'd1});
    exp_a.push_back({16'h0004, 32'd0});
    exp_a.push_back({16'h0100, 32'd24});
    exp_a.push_back({16'h0104, 32'd25});
    exp_a.push_back({16'h0108, 32'd26});
    avail_a = 32;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!(avalid_a && addr_a == 16'h010C) && n < 200) begin tick(); n++; end
    chk("t4_reach_010c", 64'(avalid_a && addr_a == 16'h010C), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_avalid", 64'(avalid_a), 64'd0);
    chk("t4_busy", 64'(busy_a), 64'd0);
    chk("t4_sready", 64'(s_ready_a), 64'd0);
    chk("t4_sb_empty", 64'(exp_a.size()), 64'd0);
    chk("t4_beats", 64'(taken_a), 64'd28);
    push_a(28); avail_a = 36;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(1'b0, 200, cyc);
    tick();
    chk("t4_done_cnt", 64'(done_cnt_a), 64'd4);
    chk("t4_sb_empty2", 64'(exp_a.size()), 64'd0);
    chk("t4_beats2", 64'(taken_a), 64'd36);

    // 128 entries x 2 words, byte-wide bus.
    push_b(); avail_b = 256;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done(1'b1, 1000, cyc);
    chk("t5_latency", 64'(cyc), 64'd520);
    tick();
    chk("t5_done_cnt", 64'(done_cnt_b), 64'd1);
    chk("t5_sb_empty", 64'(exp_b.size()), 64'd0);
    chk("t5_beats", 64'(taken_b), 64'd256);
    chk("t5_busy_low", 64'(busy_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
